// File: rtl/simd_csa_resolve_if.sv
// Handshake/data bundle between the carry-save multiplier stage, the
// resolver and the correlated-randomness output buffer.
interface simd_csa_resolve_if;

    typedef logic [255:0] prng_t;

    typedef struct packed {
        logic is256;
        logic is128;
        logic is64;
    } width_t;

    prng_t  ps_i;
    prng_t  sc_i;
    width_t width_i;
    logic   in_valid_i;
    logic   in_ready_o;
    prng_t  res_o;
    logic   out_valid_o;
    logic   out_ready_i;

    // Resolver side
    modport slave (
        input  ps_i,
        input  sc_i,
        input  width_i,
        input  in_valid_i,
        output in_ready_o,
        output res_o,
        output out_valid_o,
        input  out_ready_i
    );

    // Producer/consumer side
    modport master (
        output ps_i,
        output sc_i,
        output width_i,
        output in_valid_i,
        input  in_ready_o,
        input  res_o,
        input  out_valid_o,
        output out_ready_i
    );

endinterface

// File: rtl/simd_csa_resolve.sv
// Iterative carry-save resolver: adds the partial-sum word and the shifted
// carry word one 32-bit chunk per cycle, with carries confined to SIMD lanes.
//
// state | meaning
// IDLE  | ready for a new (ps, sc, width) triple
// RUN   | resolving chunk k_q, carry c_q from the previous chunk
// DONE  | result held on res_o until the consumer takes it
module simd_csa_resolve (
    input  logic               clk_i,
    input  logic               rst_n_i,
    simd_csa_resolve_if.slave  bus
);

    localparam int LEN    = 256;
    localparam int CHUNK  = 32;
    localparam int NCHUNK = LEN / CHUNK;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [LEN-1:0]     ps_q, ps_d;
    logic [LEN-1:0]     sc2_q, sc2_d;
    logic [LEN-1:0]     res_q, res_d;
    logic [NCHUNK-1:0]  b_q, b_d;
    logic [2:0]         k_q, k_d;
    logic               c_q, c_d;

    logic [NCHUNK-1:0]  b_acc;
    logic [LEN-1:0]     lane_clr;
    logic [LEN-1:0]     sc2_acc;
    logic [7:0]         base;
    logic [CHUNK-1:0]   chunk_ps;
    logic [CHUNK-1:0]   chunk_sc;
    logic               cin;
    logic [CHUNK:0]     sum;

    // Lane-start mask from the width fields (widest lane wins on multi-hot)
    // and the carry word shifted into place with lane-crossing bits killed.
    always_comb begin
        b_acc = {NCHUNK{1'b1}};
        if (bus.width_i.is256) begin
            b_acc = 8'h01;
        end else if (bus.width_i.is128) begin
            b_acc = 8'h11;
        end else if (bus.width_i.is64) begin
            b_acc = 8'h55;
        end
        lane_clr = '0;
        for (int k = 0; k < NCHUNK; k++) begin
            lane_clr[k*CHUNK] = b_acc[k];
        end
        sc2_acc = (bus.sc_i << 1) & ~lane_clr;
    end

    // One chunk of the ripple: carry-in is suppressed at a lane start.
    always_comb begin
        base     = {k_q, 5'b00000};
        chunk_ps = ps_q[base +: CHUNK];
        chunk_sc = sc2_q[base +: CHUNK];
        cin      = c_q & ~b_q[k_q];
        sum      = {1'b0, chunk_ps} + {1'b0, chunk_sc} + {{CHUNK{1'b0}}, cin};
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        ps_d    = ps_q;
        sc2_d   = sc2_q;
        res_d   = res_q;
        b_d     = b_q;
        k_d     = k_q;
        c_d     = c_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid_i) begin
                    ps_d    = bus.ps_i;
                    sc2_d   = sc2_acc;
                    b_d     = b_acc;
                    k_d     = '0;
                    c_d     = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                res_d[base +: CHUNK] = sum[CHUNK-1:0];
                c_d = sum[CHUNK];
                k_d = k_q + 3'd1;
                if (k_q == 3'(NCHUNK - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            ps_q    <= '0;
            sc2_q   <= '0;
            res_q   <= '0;
            b_q     <= '0;
            k_q     <= '0;
            c_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            ps_q    <= ps_d;
            sc2_q   <= sc2_d;
            res_q   <= res_d;
            b_q     <= b_d;
            k_q     <= k_d;
            c_q     <= c_d;
        end
    end

    assign bus.in_ready_o  = (state_q == IDLE);
    assign bus.out_valid_o = (state_q == DONE);
    assign bus.res_o       = res_q;

endmodule
